// File: rtl/lfsr_rr_server.sv
// Round-robin server handing out words of one shared Fibonacci LFSR to NREQ requesters.
// Build option: define LFSR_FREE_RUN_EN to let the LFSR step every READY cycle.
module lfsr_rr_server #(
  parameter int               WIDTH  = 4,
  parameter int               NREQ   = 4,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(4'b1100),
  parameter int               WARMUP = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] rnd,
  output logic             rnd_valid,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(WARMUP + 1);
  localparam logic [CW-1:0] WARM_INIT = CW'(WARMUP);

`ifdef LFSR_FREE_RUN_EN
  localparam bit FREE_RUN = 1'b1;
`else
  localparam bit FREE_RUN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_READY = 2'd1,
    ST_SEED  = 2'd2
  } state_t;

  // Handshake: req is a level, sampled on the rising edge while READY; the
  // matching gnt/rnd/rnd_valid appear for exactly the following cycle.
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lfsr, w_lfsr_nxt;
  logic [WIDTH-1:0] r_rnd, w_rnd_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic             r_valid, w_valid_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  logic [WIDTH-1:0] w_lfsr_step;
  logic [WIDTH-1:0] w_seed_fix;
  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_ptr_adv;

  assign w_lfsr_step = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
  // The all-zero state is a lock-up state for this LFSR, so it is never loaded.
  assign w_seed_fix  = (seed == '0) ? WIDTH'(1) : seed;

  always_comb begin : rr_pick
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req[PW'(idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
  end

  assign w_ptr_adv = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = '0;
    w_valid_nxt = 1'b0;
    w_rnd_nxt   = r_rnd;
    w_ptr_nxt   = r_ptr;
    if (seed_load) begin
      w_lfsr_nxt  = w_seed_fix;
      w_state_nxt = ST_SEED;
    end else begin
      case (r_state)
        ST_WARM: begin
          w_lfsr_nxt = w_lfsr_step;
          if (r_cnt <= CW'(1)) w_state_nxt = ST_READY;
          else                 w_cnt_nxt   = r_cnt - CW'(1);
        end
        ST_SEED: begin
          w_cnt_nxt   = WARM_INIT;
          w_state_nxt = ST_WARM;
        end
        ST_READY: begin
          if (FREE_RUN || w_found) w_lfsr_nxt = w_lfsr_step;
          if (w_found) begin
            w_gnt_nxt   = NREQ'(1) << w_win;
            w_rnd_nxt   = r_lfsr;
            w_valid_nxt = 1'b1;
            w_ptr_nxt   = w_ptr_adv;
          end
        end
        default: w_state_nxt = ST_WARM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_WARM;
      r_lfsr  <= WIDTH'(1);
      r_cnt   <= WARM_INIT;
      r_gnt   <= '0;
      r_rnd   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_rnd   <= w_rnd_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign rnd         = r_rnd;
  assign rnd_valid   = r_valid;
  assign busy        = (r_state != ST_READY);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Directed bench for lfsr_rr_server: cycle-by-cycle comparison against a
// behavioural model plus literal expectations taken from hand-walked sequences.
module tb_lfsr_rr_server;

  localparam int WIDTH  = 4;
  localparam int NREQ   = 4;
  localparam int TAPS   = 12;
  localparam int WARMUP = 3;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             seed_load = 1'b0;
  logic [WIDTH-1:0] seed = '0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] rnd;
  logic             rnd_valid;
  logic             busy;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  lfsr_rr_server dut (
    .clk(clk), .rstn(rstn), .seed_load(seed_load), .seed(seed), .req(req),
    .gnt(gnt), .rnd(rnd), .rnd_valid(rnd_valid), .busy(busy),
    .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_lfsr, m_ptr, m_warm_left, m_gnt, m_rnd, m_valid;
  bit m_in_seed;

  function automatic int lfsr_next(input int v);
    int fb;
    fb = $countones(v & TAPS) % 2;
    return (v * 2 + fb) % (1 << WIDTH);
  endfunction

  task automatic model_reset();
    m_lfsr = 1; m_ptr = 0; m_warm_left = WARMUP; m_in_seed = 1'b0;
    m_gnt = 0; m_rnd = 0; m_valid = 0;
  endtask

  task automatic model_step(input int r, input bit sl, input int sd);
    int win;
    m_gnt = 0; m_valid = 0;
    if (sl) begin
      m_lfsr = (sd == 0) ? 1 : sd;
      m_in_seed = 1'b1;
      m_warm_left = WARMUP;
    end else if (m_in_seed) begin
      m_in_seed = 1'b0;
    end else if (m_warm_left > 0) begin
      m_lfsr = lfsr_next(m_lfsr);
      m_warm_left--;
    end else begin
      win = -1;
      for (int i = 0; i < NREQ; i++)
        if (win < 0 && r[(m_ptr + i) % NREQ]) win = (m_ptr + i) % NREQ;
      if (win >= 0) begin
        m_gnt = 1 << win;
        m_rnd = m_lfsr;
        m_valid = 1;
        m_ptr = (win + 1) % NREQ;
        m_lfsr = lfsr_next(m_lfsr);
      end
`ifdef LFSR_FREE_RUN_EN
      else m_lfsr = lfsr_next(m_lfsr);
`endif
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step(int'(req), seed_load, int'(seed));
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("model_gnt",   int'(gnt),       m_gnt);
      check("model_rnd",   int'(rnd),       m_rnd);
      check("model_valid", int'(rnd_valid), m_valid);
      check("model_busy",  int'(busy),      int'(m_in_seed || m_warm_left > 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [NREQ-1:0] r, input logic sl, input logic [WIDTH-1:0] sd);
    @(posedge clk); #2;
    req = r; seed_load = sl; seed = sd;
  endtask

  task automatic set_rstn(input logic v);
    @(posedge clk); #2;
    rstn = v;
  endtask

  // Called at a negedge; counts cycles with busy=1, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  int nb;
  logic [NREQ-1:0]  exp_g[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [WIDTH-1:0] exp_r[5] = '{4'd3, 4'd6, 4'd13, 4'd10, 4'd5};
  logic [NREQ-1:0]  tab_req[8] = '{4'b0101, 4'b0101, 4'b1000, 4'b0000,
                                   4'b0110, 4'b0110, 4'b1001, 4'b1001};
  logic             tab_sl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [WIDTH-1:0] tab_sd[8]  = '{4'd0, 4'd0, 4'd0, 4'd10, 4'd0, 4'd7, 4'd0, 4'd0};

  initial begin
    check("pin_model_step9", lfsr_next(4), 9);
    check("pin_model_step13", lfsr_next(6), 13);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_rnd", int'(rnd), 0);
    check("rst_valid", int'(rnd_valid), 0);
    check("rst_busy", int'(busy), 1);

    // warm-up after reset release
    set_rstn(1'b1);
    @(negedge clk);
    count_busy(nb);
    check("warm_busy_cycles", nb, WARMUP);
    check("pin_model_lfsr", m_lfsr, 9);

    // single request pulse
    drive(4'b0001, 1'b0, '0);
    drive(4'b0000, 1'b0, '0);
    @(negedge clk);
`ifndef LFSR_FREE_RUN_EN
    check("first_gnt", int'(gnt), 1);
    check("first_rnd", int'(rnd), 9);
`endif
    check("first_valid", int'(rnd_valid), 1);
    @(negedge clk);
    check("idle_valid", int'(rnd_valid), 0);
    check("idle_gnt", int'(gnt), 0);
`ifndef LFSR_FREE_RUN_EN
    check("idle_rnd_hold", int'(rnd), 9);
`endif

    // all requesters for 5 cycles
    drive(4'b1111, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      if (k == 4) req = '0;
      @(negedge clk);
`ifndef LFSR_FREE_RUN_EN
      check($sformatf("rr_gnt%0d", k), int'(gnt), int'(exp_g[k]));
      check($sformatf("rr_rnd%0d", k), int'(rnd), int'(exp_r[k]));
`endif
      check($sformatf("rr_valid%0d", k), int'(rnd_valid), 1);
    end

    // seed_load of zero together with requests
    drive(4'b1111, 1'b1, 4'd0);
    drive(4'b1111, 1'b0, 4'd0);
    @(negedge clk);
    check("seed_no_gnt", int'(gnt), 0);
    count_busy(nb);
    check("seed_busy_cycles", nb, WARMUP + 1);
    @(negedge clk);
    check("seed_first_rnd", int'(rnd), 9);
    check("seed_first_gnt", int'(gnt), 4'b0100);

    // reset in the middle of a grant stream
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_rnd", int'(rnd), 0);
    check("midrst_valid", int'(rnd_valid), 0);
    check("midrst_busy", int'(busy), 1);
    set_rstn(1'b0);
    set_rstn(1'b1);
    @(negedge clk);
    count_busy(nb);
    check("midrst_warm_cycles", nb, WARMUP);
    @(negedge clk);
    check("midrst_first_gnt", int'(gnt), 1);
    check("midrst_first_rnd", int'(rnd), 9);

    // mixed vectors, incl. seed reload during warm-up
    for (int k = 0; k < 8; k++) drive(tab_req[k], tab_sl[k], tab_sd[k]);
    drive(4'b1001, 1'b0, '0);
    repeat (10) @(posedge clk);
    drive(4'b0000, 1'b0, '0);
    repeat (3) @(posedge clk);

`ifdef LFSR_FREE_RUN_EN
    set_rstn(1'b0);
    set_rstn(1'b1);
    @(negedge clk);
    count_busy(nb);
    @(posedge clk);
    drive(4'b0001, 1'b0, '0);
    drive(4'b0000, 1'b0, '0);
    @(negedge clk);
    check("free_run_rnd", int'(rnd), 6);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
